// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction-memory loader: loader state
// encodings, the default halt word and the byte-lane merge helper.
package imem_loader_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    LD_LOAD  = 3'd0,
    LD_WRITE = 3'd1,
    LD_CHECK = 3'd2,
    LD_RUN   = 3'd3,
    LD_ERROR = 3'd4
  } ld_state_e;

  localparam word_t HALT_WORD_DEF = 32'h0000_0000;

  // Little-endian placement: lane 0 lands in bits [7:0].
  function automatic word_t merge_byte(input word_t w, input logic [1:0] lane,
                                       input logic [7:0] b);
    word_t r;
    r = w;
    r[8*lane +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write-port bundle of the loader.
// slave = loader side, master = stream source / imem side.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  import imem_loader_pkg::*;

  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  word_t             imem_wdata;

  modport master (
    output rx_valid, rx_byte,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_byte,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_assembler.sv
// imem_word_assembler: packs four accepted stream bytes into a 32-bit word
// and pulses word_valid for one cycle after the lane-3 byte.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       byte_fire,
  input  logic [7:0] byte_in,
  output logic       last_lane,
  output logic       word_valid,
  output word_t      word
);

  logic [1:0] lane_p0;
  logic       vld_p1;
  word_t      word_p1;

  // Stage p0 -> p1: lane bookkeeping and word merge
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      lane_p0 <= 2'd0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= byte_fire && (lane_p0 == 2'd3);
      if (byte_fire) lane_p0 <= lane_p0 + 2'd1;
    end
  end

  // Every lane is overwritten before word_valid, so no clear is needed here.
  always_ff @(posedge clk) begin
    if (byte_fire) word_p1 <= merge_byte(word_p1, lane_p0, byte_in);
  end

  assign last_lane  = (lane_p0 == 2'd3);
  assign word_valid = vld_p1;
  assign word       = word_p1;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into words, writes them
// to imem from address 0 and releases the CPU after the halt word.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int    IMEM_DEPTH = 64,
  parameter int    ADDR_W     = 6,
  parameter word_t HALT_WORD  = HALT_WORD_DEF
) (
  input  logic            clk,
  input  logic            reset,
  imem_loader_if.slave    bus,
  output logic            cpu_reset,
  output logic            load_done,
  output logic            load_error,
  output logic [ADDR_W:0] word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(IMEM_DEPTH);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              load_fire;
  logic              last_lane;
  logic              word_valid;
  word_t             word;
  logic              is_halt;

  assign load_fire = bus.rx_valid && (state_q == LD_LOAD);
  assign is_halt   = (word == HALT_WORD);

  imem_word_assembler u_asm (
    .clk       (clk),
    .clear     (reset),
    .byte_fire (load_fire),
    .byte_in   (bus.rx_byte),
    .last_lane (last_lane),
    .word_valid(word_valid),
    .word      (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          csum_q <= 8'h00;
    else if (load_fire) csum_q <= csum_q ^ bus.rx_byte;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LD_LOAD;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == LD_WRITE) begin
        if (count_q != MAX_COUNT) count_q <= count_q + 1'b1;
        // Overflow keeps the address pinned; ERROR follows.
        if (!is_halt && addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_LOAD:  if (load_fire && last_lane) state_d = LD_WRITE;
      LD_WRITE: begin
        if (is_halt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = LD_CHECK;
`else
          state_d = LD_RUN;
`endif
        end else if (addr_q == LAST_ADDR) begin
          state_d = LD_ERROR;
        end else begin
          state_d = LD_LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CHECK: if (bus.rx_valid) state_d = (bus.rx_byte == csum_q) ? LD_RUN : LD_ERROR;
`endif
      default:  state_d = state_q;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.rx_ready = (state_q == LD_LOAD) || (state_q == LD_CHECK);
`else
  assign bus.rx_ready = (state_q == LD_LOAD);
`endif
  assign bus.imem_we    = (state_q == LD_WRITE) && word_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = (state_q == LD_WRITE) ? word : '0;

  assign cpu_reset  = reset || (state_q != LD_RUN);
  assign load_done  = (state_q == LD_RUN);
  assign load_error = (state_q == LD_ERROR);
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 64-word instance for normal loads and a
// 4-word instance for the overflow path.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(6)) bus_a ();
  imem_loader_if #(.ADDR_W(2)) bus_b ();

  logic       cpu_reset_a, load_done_a, load_error_a;
  logic [6:0] word_count_a;
  logic       cpu_reset_b, load_done_b, load_error_b;
  logic [2:0] word_count_b;

  imem_loader #(.IMEM_DEPTH(64), .ADDR_W(6)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .cpu_reset(cpu_reset_a), .load_done(load_done_a),
    .load_error(load_error_a), .word_count(word_count_a)
  );

  imem_loader #(.IMEM_DEPTH(4), .ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .cpu_reset(cpu_reset_b), .load_done(load_done_b),
    .load_error(load_error_b), .word_count(word_count_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Write logs, filled only by the monitors below.
  logic [5:0]  la_addr [64];
  logic [31:0] la_data [64];
  int          na = 0;
  int          a_busy_writes = 0;
  logic [1:0]  lb_addr [16];
  logic [31:0] lb_data [16];
  int          nb = 0;

  always @(negedge clk) begin
    if (bus_a.imem_we && na < 64) begin
      la_addr[na] = bus_a.imem_addr;
      la_data[na] = bus_a.imem_wdata;
      na = na + 1;
      if (bus_a.rx_ready) a_busy_writes = a_busy_writes + 1;
    end
    if (bus_b.imem_we && nb < 16) begin
      lb_addr[nb] = bus_b.imem_addr;
      lb_data[nb] = bus_b.imem_wdata;
      nb = nb + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus_a.rx_valid = 1'b0;
    bus_b.rx_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Returns at posedge+1 after the byte was accepted.
  task automatic send(input bit sel_b, input logic [7:0] d, input int idle);
    bit done;
    logic rdy;
    repeat (idle) begin @(posedge clk); #1; end
    if (sel_b) begin bus_b.rx_valid = 1'b1; bus_b.rx_byte = d; end
    else       begin bus_a.rx_valid = 1'b1; bus_a.rx_byte = d; end
    done = 1'b0;
    rdy  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = sel_b ? bus_b.rx_ready : bus_a.rx_ready;
      if (rdy) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", {31'd0, rdy}, 32'd1);
    bus_a.rx_valid = 1'b0;
    bus_b.rx_valid = 1'b0;
  endtask

  logic [7:0] s1 [12] = '{8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01, 8'h00, 8'h00,
                          8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] s5 [8]  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
  int base;

  initial begin
    bus_a.rx_valid = 1'b0; bus_a.rx_byte = 8'h00;
    bus_b.rx_valid = 1'b0; bus_b.rx_byte = 8'h00;
    #12;
    // Reset values while reset is held
    check("rst_rx_ready",   {31'd0, bus_a.rx_ready},   32'd1);
    check("rst_cpu_reset",  {31'd0, cpu_reset_a},     32'd1);
    check("rst_imem_we",    {31'd0, bus_a.imem_we},    32'd0);
    check("rst_load_done",  {31'd0, load_done_a},     32'd0);
    check("rst_load_error", {31'd0, load_error_a},    32'd0);
    check("rst_word_count", {25'd0, word_count_a},    32'd0);
    check("rst_imem_addr",  {26'd0, bus_a.imem_addr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Three-word program, back to back
    base = na;
    for (int i = 0; i < 12; i++) send(1'b0, s1[i], 0);
    check("t1_we_in_write",    {31'd0, bus_a.imem_we},    32'd1);
    check("t1_halt_addr",      {26'd0, bus_a.imem_addr},  32'd2);
    check("t1_halt_wdata",     bus_a.imem_wdata,          32'h0);
    check("t1_ready_in_write", {31'd0, bus_a.rx_ready},   32'd0);
    check("t1_cpu_reset_held", {31'd0, cpu_reset_a},      32'd1);
    @(posedge clk); #1;
    check("t1_load_done",  {31'd0, load_done_a},  32'd1);
    check("t1_cpu_reset",  {31'd0, cpu_reset_a},  32'd0);
    check("t1_word_count", {25'd0, word_count_a}, 32'd3);
    check("t1_rx_ready",   {31'd0, bus_a.rx_ready}, 32'd0);
    check("t1_nwrites", na - base, 3);
    check("t1_w0_addr", {26'd0, la_addr[base]},   32'd0);
    check("t1_w0_data", la_data[base],            32'h00A00093);
    check("t1_w1_addr", {26'd0, la_addr[base+1]}, 32'd1);
    check("t1_w1_data", la_data[base+1],          32'h00000113);
    check("t1_w2_data", la_data[base+2],          32'h00000000);
    repeat (3) @(posedge clk);
    #1;
    check("t1_run_stays", {31'd0, load_done_a}, 32'd1);

    // Same stream with 1-3 idle cycles between bytes
    do_reset();
    base = na;
    for (int i = 0; i < 12; i++) send(1'b0, s1[i], $urandom_range(1, 3));
    @(posedge clk); #1;
    check("t3_nwrites", na - base, 3);
    check("t3_w0_data", la_data[base],   32'h00A00093);
    check("t3_w1_data", la_data[base+1], 32'h00000113);
    check("t3_w2_addr", {26'd0, la_addr[base+2]}, 32'd2);
    check("t3_load_done", {31'd0, load_done_a}, 32'd1);
    check("t3_busy_writes", a_busy_writes, 0);

    // Reset after six bytes, then a fresh two-word stream
    do_reset();
    for (int i = 0; i < 6; i++) send(1'b0, 8'h11 * (i + 1), 0);
    do_reset();
    check("t5_count_after_rst", {25'd0, word_count_a}, 32'd0);
    base = na;
    for (int i = 0; i < 8; i++) send(1'b0, s5[i], 0);
    @(posedge clk); #1;
    check("t5_nwrites", na - base, 2);
    check("t5_w0_addr", {26'd0, la_addr[base]},   32'd0);
    check("t5_w0_data", la_data[base],            32'h12345678);
    check("t5_w1_addr", {26'd0, la_addr[base+1]}, 32'd1);
    check("t5_word_count", {25'd0, word_count_a}, 32'd2);
    check("t5_cpu_reset",  {31'd0, cpu_reset_a},  32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // XOR of the three-word stream is 0x21
    do_reset();
    for (int i = 0; i < 12; i++) send(1'b0, s1[i], 0);
    send(1'b0, 8'h21, 0);
    check("cs_good_done", {31'd0, load_done_a}, 32'd1);
    do_reset();
    for (int i = 0; i < 12; i++) send(1'b0, s1[i], 0);
    send(1'b0, 8'h20, 0);
    check("cs_bad_error",     {31'd0, load_error_a}, 32'd1);
    check("cs_bad_cpu_reset", {31'd0, cpu_reset_a},  32'd1);
`endif

    // Four non-halt words into a 4-word imem
    do_reset();
    for (int w = 1; w <= 4; w++) begin
      send(1'b1, 8'(w), 0);
      send(1'b1, 8'h00, 0);
      send(1'b1, 8'h00, 0);
      send(1'b1, 8'h00, 0);
    end
    check("t4_w3_addr",  {30'd0, bus_b.imem_addr}, 32'd3);
    check("t4_w3_data",  bus_b.imem_wdata,         32'h00000004);
    @(posedge clk); #1;
    check("t4_nwrites",    nb, 4);
    check("t4_w0_data",    lb_data[0], 32'h00000001);
    check("t4_load_error", {31'd0, load_error_b},  32'd1);
    check("t4_cpu_reset",  {31'd0, cpu_reset_b},   32'd1);
    check("t4_rx_ready",   {31'd0, bus_b.rx_ready}, 32'd0);
    check("t4_load_done",  {31'd0, load_done_b},   32'd0);
    check("t4_word_count", {29'd0, word_count_b},  32'd4);
    check("t4_addr_pinned", {30'd0, bus_b.imem_addr}, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
